// File: rtl/vme_rd_arbiter.sv
// Two-client round-robin arbiter for the VME read channel; one burst in flight, data steered to the owner.
// Optional tag filtering of return beats is enabled by defining VME_RD_ARB_TAG_CHECK_EN.
module vme_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int TAG_W  = 21,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c0_cmd_valid,
  output logic              c0_cmd_ready,
  input  logic [ADDR_W-1:0] c0_cmd_addr,
  input  logic [LEN_W-1:0]  c0_cmd_len,
  input  logic [TAG_W-1:0]  c0_cmd_tag,
  input  logic              c1_cmd_valid,
  output logic              c1_cmd_ready,
  input  logic [ADDR_W-1:0] c1_cmd_addr,
  input  logic [LEN_W-1:0]  c1_cmd_len,
  input  logic [TAG_W-1:0]  c1_cmd_tag,
  output logic              c0_data_valid,
  output logic              c1_data_valid,
  output logic [DATA_W-1:0] cx_data_bits,
  output logic [TAG_W-1:0]  cx_data_tag,
  output logic              cx_data_last,
  output logic              vme_cmd_valid,
  input  logic              vme_cmd_ready,
  output logic [ADDR_W-1:0] vme_cmd_addr,
  output logic [LEN_W-1:0]  vme_cmd_len,
  output logic [TAG_W-1:0]  vme_cmd_tag,
  input  logic              vme_data_valid,
  input  logic [DATA_W-1:0] vme_data_bits,
  input  logic [TAG_W-1:0]  vme_data_tag,
  input  logic              vme_data_last,
  output logic              busy,
  output logic              owner,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             winner;
  logic             cmd_vld;
  logic             tag_ok;

`ifdef VME_RD_ARB_TAG_CHECK_EN
  logic [TAG_W-1:0] tag_q, tag_d;
  assign tag_ok = (vme_data_tag == tag_q);
`else
  assign tag_ok = 1'b1;
`endif

  assign cx_data_bits = vme_data_bits;
  assign cx_data_tag  = vme_data_tag;
  assign cx_data_last = vme_data_last;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;
  assign err          = err_q;

  // Contention goes to the client that was not served last.
  assign winner = (c0_cmd_valid && c1_cmd_valid) ? ~rr_last_q : c1_cmd_valid;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
`ifdef VME_RD_ARB_TAG_CHECK_EN
    tag_d         = tag_q;
`endif
    cmd_vld       = 1'b0;
    vme_cmd_valid = 1'b0;
    vme_cmd_addr  = '0;
    vme_cmd_len   = '0;
    vme_cmd_tag   = '0;
    c0_cmd_ready  = 1'b0;
    c1_cmd_ready  = 1'b0;
    c0_data_valid = 1'b0;
    c1_data_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (vme_data_valid) err_d = 1'b1;
        if (c0_cmd_valid || c1_cmd_valid) begin
          owner_d = winner;
          cnt_d   = winner ? c1_cmd_len : c0_cmd_len;
          state_d = CMD;
        end
      end
      CMD: begin
        if (vme_data_valid) err_d = 1'b1;
        cmd_vld       = owner_q ? c1_cmd_valid : c0_cmd_valid;
        vme_cmd_valid = cmd_vld;
        vme_cmd_addr  = owner_q ? c1_cmd_addr : c0_cmd_addr;
        vme_cmd_len   = owner_q ? c1_cmd_len  : c0_cmd_len;
        vme_cmd_tag   = owner_q ? c1_cmd_tag  : c0_cmd_tag;
        c0_cmd_ready  = ~owner_q & vme_cmd_ready;
        c1_cmd_ready  =  owner_q & vme_cmd_ready;
        if (cmd_vld && vme_cmd_ready) begin
`ifdef VME_RD_ARB_TAG_CHECK_EN
          tag_d = owner_q ? c1_cmd_tag : c0_cmd_tag;
`endif
          rr_last_d = owner_q;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (vme_data_valid) begin
          if (tag_ok) begin
            c0_data_valid = ~owner_q;
            c1_data_valid =  owner_q;
            // Burst ends on whichever comes first: last flag or exhausted count.
            if (vme_data_last || cnt_q == '0) begin
              state_d = IDLE;
              if (vme_data_last != (cnt_q == '0)) err_d = 1'b1;
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef VME_RD_ARB_TAG_CHECK_EN
      tag_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef VME_RD_ARB_TAG_CHECK_EN
      tag_q     <= tag_d;
`endif
    end
  end

endmodule

// File: doc/vme_rd_arbiter.md
# vme_rd_arbiter

Two-client arbiter for the VME read channel. It shares one read-command/read-data port between client 0 (the uop loader) and client 1 (the tensor/input loader). Each granted burst runs to completion: one command handshake, then every data beat up to and including `last`. Return data is steered to the owning client, and the channel is released afterwards. Only one burst is outstanding on the VME port at any time.

## Interface
Parameters
- `ADDR_W`, 32: VME address width
- `LEN_W`, 8: burst length field; beats = len+1
- `TAG_W`, 21: command/data tag width
- `DATA_W`, 64: read data width

Ports
- `clock`  in  1: single clock, rising edge
- `reset`  in  1: synchronous, active-low (0 = reset, sampled on `clock`)
- `c0_cmd_valid`, `c1_cmd_valid`  in  1 each: client read request
- `c0_cmd_ready`, `c1_cmd_ready`  out  1 each: client command accepted
- `c0_cmd_addr`, `c1_cmd_addr`  in  ADDR_W: burst base address
- `c0_cmd_len`, `c1_cmd_len`  in  LEN_W: burst length minus one
- `c0_cmd_tag`, `c1_cmd_tag`  in  TAG_W: client tag
- `c0_data_valid`, `c1_data_valid`  out  1 each: beat for this client
- `cx_data_bits`, `cx_data_tag`, `cx_data_last`  out  DATA_W / TAG_W / 1: shared beat payload, broadcast to both clients
- `vme_cmd_valid`  out  1; `vme_cmd_ready`  in  1
- `vme_cmd_addr`, `vme_cmd_len`, `vme_cmd_tag`  out  ADDR_W / LEN_W / TAG_W
- `vme_data_valid`  in  1; `vme_data_bits`, `vme_data_tag`, `vme_data_last`  in  DATA_W / TAG_W / 1
- `busy`  out  1: state != IDLE
- `owner`  out  1: client currently granted
- `err`  out  1: sticky protocol error, cleared only by reset

## Operation
- FSM states: IDLE, CMD, DATA.
- **IDLE**
  - If any `cN_cmd_valid` is high, pick a winner by round-robin. `rr_last` holds the last-served client; the other client has priority.
  - Register `owner`, set `cnt` = winner len, go to CMD.
  - If both clients request with `rr_last`=0, client 1 wins.
- **CMD**
  - `vme_cmd_*` mirror the owner's `cN_cmd_*` combinationally.
  - `vme_cmd_valid` = owner's valid.
  - Owner's `cmd_ready` = `vme_cmd_ready`. The non-owner's `cmd_ready` is 0.
  - On the handshake: latch the issued tag, set `rr_last` = owner, go to DATA.
  - If the owner drops valid before the handshake, wait in CMD. The grant is not revoked.
- **DATA**
  - `cN_data_valid` = `vme_data_valid` when N == owner, else 0. No backpressure on the data path.
  - `cx_data_*` = `vme_data_*` at all times.
  - Each accepted beat: if `cnt`==0, the beat ends the burst; otherwise `cnt` decrements.
  - Burst end goes to IDLE on the same edge. It is the earlier of `vme_data_last`=1 or `cnt`==0.
  - `last`=1 while `cnt`!=0 sets `err` (early last).
  - `cnt`==0 with `last`=0 sets `err` (missing last). The burst still ends.
- `cnt` is LEN_W wide. len=0xFF means 256 beats and must not wrap early.
- `vme_data_valid` in IDLE or CMD: the beat is dropped and `err` is set.
- Reset mid-burst: FSM goes to IDLE, `rr_last`=1 (client 0 wins first), `err`=0. In-flight beats after reset hit the IDLE rule above.

## Timing
- Reset values:
  - `busy`=0, `owner`=0, `err`=0.
  - `vme_cmd_valid`=0, both `cmd_ready`=0, both `data_valid`=0.
  - `vme_cmd_addr/len/tag`=0.
- Arbitration latency: a request seen in IDLE at cycle t drives `vme_cmd_valid`=1 at t+1, earliest handshake at t+1.
- Data steering has zero cycles of latency (combinational).
- Burst end at edge t: IDLE at t+1, next grant visible at t+2. Back-to-back bursts therefore carry a minimum 2-cycle gap on `vme_cmd_valid`.
- All state, including `err`, updates on the rising edge only.

## Configuration
- Macro `VME_RD_ARB_TAG_CHECK_EN`.
- Defined:
  - In DATA, a beat with `vme_data_tag` != the latched issued tag is dropped: no `cN_data_valid`, `cnt` unchanged, `err` set.
  - Matching beats behave as normal.
- Undefined: tags are ignored, no latch register is instantiated, and all DATA beats are forwarded.

## Test plan
- **Single burst:** c0 requests addr 0x1000, len 3, tag 5, ready=1 → one vme cmd with identical fields, 4 beats on `c0_data_valid` only, last on beat 4, `busy` low 1 cycle later, `err`=0.
- **Simultaneous requests after reset:** both valid, len 0 each → c0 served first, then c1, `vme_cmd_valid` gap of 2 cycles, `owner` 0→1.
- **Stalled command:** `vme_cmd_ready`=0 for 5 cycles with c1 valid throughout → `vme_cmd_valid` held 5 cycles, c0 request raised meanwhile is not granted until c1's burst completes.
- **Protocol errors:** len 3 with `last` on beat 2 → burst ends after beat 2, `err`=1 and stays 1. Separately, len 1 with no last → ends after beat 2, `err`=1.
- **Max length and stray beat:** len 0xFF → exactly 256 beats forwarded. A `vme_data_valid` pulse in IDLE → no client valid, `err`=1.
- **Tag check** (with `VME_RD_ARB_TAG_CHECK_EN`): issued tag 7, beat 2 carries tag 9 → beat 2 suppressed, `err`=1, burst still completes on the next tag-7 beat carrying last. Without the macro, all beats are forwarded.
